// File: rtl/button_event_if.sv
// Button event bus: deglitched level and ack in, classified gesture events out.
// Optional auto-repeat in the block itself is enabled by BUTTON_EVENT_REPEAT_EN.
interface button_event_if;
  logic       btn_in;
  logic       evt_ack;
  logic       pressed;
  logic       evt_short;
  logic       evt_long;
  logic       evt_double;
  logic       evt_pend;
  logic [1:0] evt_code;
  logic       evt_ovf;
  logic [2:0] dbg_state;

  // Handshake: evt_* are one-cycle valid pulses with no back-pressure; evt_pend holds
  // evt_code valid until firmware answers with a one-cycle evt_ack (the ready side).
  modport master (
    output btn_in, evt_ack,
    input  pressed, evt_short, evt_long, evt_double, evt_pend, evt_code, evt_ovf, dbg_state
  );

  modport slave (
    input  btn_in, evt_ack,
    output pressed, evt_short, evt_long, evt_double, evt_pend, evt_code, evt_ovf, dbg_state
  );
endinterface

// File: rtl/button_event.sv
// Classifies a deglitched button level into short / long / double-click events.
// Define BUTTON_EVENT_REPEAT_EN to re-issue evt_long every REPEAT_MS while held.
module button_event #(
  parameter int TICK_DIV  = 50000,
  parameter int LONG_MS   = 800,
  parameter int DOUBLE_MS = 250,
  parameter int REPEAT_MS = 200
) (
  input  logic          clk,
  input  logic          rstn,
  button_event_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PRESS  = 3'd1,
    S_WAIT2  = 3'd2,
    S_PRESS2 = 3'd3,
    S_HELD   = 3'd4
  } state_t;

  localparam logic [1:0] EV_NONE   = 2'b00;
  localparam logic [1:0] EV_SHORT  = 2'b01;
  localparam logic [1:0] EV_LONG   = 2'b10;
  localparam logic [1:0] EV_DOUBLE = 2'b11;

  localparam int               PRE_W     = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [15:0]      LONG_TH   = 16'(LONG_MS);
  localparam logic [15:0]      DOUBLE_TH = 16'(DOUBLE_MS);
`ifdef BUTTON_EVENT_REPEAT_EN
  localparam logic [15:0]      REPEAT_TH = 16'(REPEAT_MS);
`endif

  if (TICK_DIV < 2 || LONG_MS < 1 || DOUBLE_MS < 0 || REPEAT_MS < 1) begin : g_param_check
    $error("button_event: illegal parameter value");
  end

  state_t           r_state;
  state_t           w_next_state;
  logic             r_pressed;
  logic [PRE_W-1:0] r_pre;
  logic [15:0]      r_ms;
  logic             r_short;
  logic             r_long;
  logic             r_double;
  logic             r_pend;
  logic [1:0]       r_code;
  logic             r_ovf;
  logic [1:0]       w_evt;
  logic             w_rise;
  logic             w_fall;
  logic             w_tick;
  logic             w_rpt;
  logic             w_restart;

  assign w_rise = bus.btn_in & ~r_pressed;
  assign w_fall = ~bus.btn_in & r_pressed;
  assign w_tick = (r_pre == PRE_LAST);

  // Edges are tested before thresholds so an edge wins a same-cycle timeout.
  always_comb begin
    w_next_state = r_state;
    w_evt        = EV_NONE;
    w_rpt        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rise) w_next_state = S_PRESS;
      end
      S_PRESS: begin
        if (w_fall) begin
          if (DOUBLE_MS == 0) begin
            w_evt        = EV_SHORT;
            w_next_state = S_IDLE;
          end else begin
            w_next_state = S_WAIT2;
          end
        end else if (r_ms >= LONG_TH) begin
          w_evt        = EV_LONG;
          w_next_state = S_HELD;
        end
      end
      S_WAIT2: begin
        if (w_rise) begin
          w_next_state = S_PRESS2;
        end else if (r_ms >= DOUBLE_TH) begin
          w_evt        = EV_SHORT;
          w_next_state = S_IDLE;
        end
      end
      S_PRESS2: begin
        if (w_fall) begin
          w_evt        = EV_DOUBLE;
          w_next_state = S_IDLE;
        end else if (r_ms >= LONG_TH) begin
          w_evt        = EV_DOUBLE;
          w_next_state = S_HELD;
        end
      end
      S_HELD: begin
        if (w_fall) begin
          w_next_state = S_IDLE;
        end
`ifdef BUTTON_EVENT_REPEAT_EN
        else if (r_ms >= REPEAT_TH) begin
          w_evt = EV_LONG;
          w_rpt = 1'b1;
        end
`endif
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Timing restarts on every state change and on each auto-repeat.
  assign w_restart = (w_next_state != r_state) | w_rpt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_pressed <= 1'b0;
      r_pre     <= '0;
      r_ms      <= '0;
      r_short   <= 1'b0;
      r_long    <= 1'b0;
      r_double  <= 1'b0;
      r_pend    <= 1'b0;
      r_code    <= EV_NONE;
      r_ovf     <= 1'b0;
    end else begin
      r_pressed <= bus.btn_in;
      r_state   <= w_next_state;
      if (w_restart) begin
        r_pre <= '0;
        r_ms  <= '0;
      end else begin
        r_pre <= w_tick ? '0 : r_pre + 1'b1;
        if (w_tick && (r_ms != 16'hFFFF)) r_ms <= r_ms + 16'd1;
      end
      r_short  <= (w_evt == EV_SHORT);
      r_long   <= (w_evt == EV_LONG);
      r_double <= (w_evt == EV_DOUBLE);
      // A new event beats a coincident ack; overflow only if the old one was unread.
      if (w_evt != EV_NONE) begin
        r_pend <= 1'b1;
        r_code <= w_evt;
        r_ovf  <= r_pend & ~bus.evt_ack;
      end else if (bus.evt_ack) begin
        r_pend <= 1'b0;
        r_code <= EV_NONE;
        r_ovf  <= 1'b0;
      end
    end
  end

  assign bus.pressed    = r_pressed;
  assign bus.evt_short  = r_short;
  assign bus.evt_long   = r_long;
  assign bus.evt_double = r_double;
  assign bus.evt_pend   = r_pend;
  assign bus.evt_code   = r_code;
  assign bus.evt_ovf    = r_ovf;
  assign bus.dbg_state  = r_state;

endmodule
